uart_rx_cmd_ctrl: RTL and testbench
===================================

// Module: uart_rx_cmd_ctrl
// PURPOSE
//  Command sequencer behind the UART receiver.
//  - Consumes validated bytes (P_DATA + data_valid) from the RX path.
//  - Parses multi-byte command frames: register write, register read, ALU with operands, ALU without operands.
//  - Drives reg-file write/read strobes, ALU enable/function and ALU clock-gate enable.
//  - Sits between the UART RX and the reg file / ALU in the system domain.
// PARAMETERS
//  DATA_WD      8     byte width of RX data and reg-file data
//  ADDR_WD      4     reg-file address width; address bytes are truncated to [ADDR_WD-1:0]
//  TIMEOUT_WD   16    inter-byte timeout counter width (used only with RX_TIMEOUT_EN)
//  TIMEOUT_VAL  5000  idle cycles between bytes before a partial frame is aborted
// PORTS
//  CLK          in   1         system clock
//  RST          in   1         asynchronous reset, active-high
//  RX_P_DATA    in   DATA_WD   received byte; valid while RX_D_VLD=1
//  RX_D_VLD     in   1         one-cycle pulse, byte received without parity/stop error
//  RX_FRM_ERR   in   1         one-cycle pulse, byte dropped for parity/stop error
//  ALU_OUT_VLD  in   1         ALU result valid pulse
//  RF_WR_EN     out  1         reg-file write strobe, 1 cycle
//  RF_RD_EN     out  1         reg-file read strobe, 1 cycle
//  RF_ADDR      out  ADDR_WD   reg-file address, held between strobes
//  RF_WR_DATA   out  DATA_WD   reg-file write data, held between strobes
//  ALU_EN       out  1         ALU start strobe, 1 cycle
//  ALU_FUN      out  4         ALU function, = function byte[3:0], held
//  CLK_GATE_EN  out  1         ALU clock-gate enable, level
//  CMD_BUSY     out  1         1 whenever state != IDLE
//  CMD_ERR      out  1         one-cycle pulse, command rejected or aborted
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including RF_ADDR, RF_WR_DATA and ALU_FUN.
//  Output timing: all outputs are registered. Strobes rise in the cycle after the accepting RX_D_VLD cycle.
//  State transitions on accepted bytes:
//   IDLE:    0xAA -> WR_ADDR;  0xBB -> RD_ADDR;
//            0xCC -> OPA, CLK_GATE_EN<=1;  0xDD -> FUN, CLK_GATE_EN<=1;
//            any other byte -> CMD_ERR pulse, stay in IDLE.
//   WR_ADDR: latch RF_ADDR -> WR_DATA.
//   WR_DATA: RF_WR_DATA<=byte, RF_WR_EN pulse -> IDLE.
//   RD_ADDR: latch RF_ADDR, RF_RD_EN pulse -> IDLE.
//   OPA:     RF_ADDR<=0, RF_WR_DATA<=byte, RF_WR_EN pulse -> OPB.
//   OPB:     RF_ADDR<=1, RF_WR_DATA<=byte, RF_WR_EN pulse -> FUN.
//   FUN:     ALU_FUN<=byte[3:0], ALU_EN pulse -> ALU_WAIT.
//   ALU_WAIT: on ALU_OUT_VLD -> IDLE, CLK_GATE_EN<=0.
//  Boundary conditions:
//   - Byte arriving in ALU_WAIT is dropped with a CMD_ERR pulse; state is unchanged.
//   - RX_FRM_ERR in WR_ADDR..FUN aborts: -> IDLE, CMD_ERR pulse, CLK_GATE_EN<=0, no strobes.
//     It is ignored in IDLE and in ALU_WAIT.
//   - RX_FRM_ERR and RX_D_VLD in the same cycle: the error wins and the byte is discarded.
//   - ALU_OUT_VLD outside ALU_WAIT is ignored.
//   - ALU_OUT_VLD and RX_D_VLD in the same cycle in ALU_WAIT: -> IDLE and the byte is dropped with CMD_ERR.
//   - Address byte bits above ADDR_WD-1 are ignored; no error is raised.
//   - Undefined state encoding -> IDLE on the next clock with outputs 0.
//   - RST mid-frame: immediate return to IDLE, all outputs 0, the partial frame is lost.
// CONFIGURATION
//  RX_TIMEOUT_EN defined:
//   - A TIMEOUT_WD counter clears on every accepted byte and on entry to IDLE.
//   - It increments only in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and FUN.
//   - When it reaches TIMEOUT_VAL-1: -> IDLE, CMD_ERR pulse, CLK_GATE_EN<=0.
//   - A byte accepted in the same cycle as the timeout wins and the counter clears.
//  RX_TIMEOUT_EN undefined: no counter; partial frames wait indefinitely; TIMEOUT_* are unused.
// TESTING
//  AA,05,3C -> one RF_WR_EN with RF_ADDR=5, RF_WR_DATA=3C; CMD_BUSY=0 after; CMD_ERR never set.
//  BB,0A -> one RF_RD_EN with RF_ADDR=A; no RF_WR_EN.
//  CC,12,34,02 -> RF_WR_EN at addr 0 (data 12), then at addr 1 (data 34); ALU_EN with ALU_FUN=2;
//   CLK_GATE_EN high from after CC until the cycle after ALU_OUT_VLD.
//  DD,07 then a byte 55 before ALU_OUT_VLD -> ALU_EN, ALU_FUN=7; 55 gives CMD_ERR, state stays ALU_WAIT.
//  AA,03 then RX_FRM_ERR -> CMD_ERR pulse, IDLE, no RF_WR_EN; unknown byte 5A in IDLE -> CMD_ERR only.
//  RX_TIMEOUT_EN, TIMEOUT_VAL=16: AA then a 16-cycle gap -> CMD_ERR and IDLE; a next byte AA starts a new frame.

Source files
------------

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Handshake bundle between the UART RX path, the command sequencer and the reg-file/ALU side.
// The slave modport is the sequencer; the master modport is whatever feeds it bytes and ALU status.
interface uart_rx_cmd_ctrl_if #(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 4
);
  logic [DATA_WD-1:0] rx_p_data;
  logic               rx_d_vld;
  logic               rx_frm_err;
  logic               alu_out_vld;
  logic               rf_wr_en;
  logic               rf_rd_en;
  logic [ADDR_WD-1:0] rf_addr;
  logic [DATA_WD-1:0] rf_wr_data;
  logic               alu_en;
  logic [3:0]         alu_fun;
  logic               clk_gate_en;
  logic               cmd_busy;
  logic               cmd_err;

  modport master (
    output rx_p_data, rx_d_vld, rx_frm_err, alu_out_vld,
    input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
           clk_gate_en, cmd_busy, cmd_err
  );

  modport slave (
    input  rx_p_data, rx_d_vld, rx_frm_err, alu_out_vld,
    output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
           clk_gate_en, cmd_busy, cmd_err
  );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// Command sequencer behind the UART receiver: parses write/read/ALU frames into reg-file and ALU strobes.
// Optional inter-byte timeout is enabled with the RX_TIMEOUT_EN macro (TIMEOUT_WD/TIMEOUT_VAL exist only then).
module uart_rx_cmd_ctrl #(
  parameter int DATA_WD = 8,
  parameter int ADDR_WD = 4
`ifdef RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_WD  = 16,
  parameter int TIMEOUT_VAL = 5000
`endif
) (
  input logic              clk,
  input logic              rst,
  uart_rx_cmd_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_WR_ADDR  = 4'd1,
    ST_WR_DATA  = 4'd2,
    ST_RD_ADDR  = 4'd3,
    ST_OPA      = 4'd4,
    ST_OPB      = 4'd5,
    ST_FUN      = 4'd6,
    ST_ALU_WAIT = 4'd7
  } state_t;

  localparam logic [DATA_WD-1:0] CMD_WR     = DATA_WD'(8'hAA);
  localparam logic [DATA_WD-1:0] CMD_RD     = DATA_WD'(8'hBB);
  localparam logic [DATA_WD-1:0] CMD_ALU_OP = DATA_WD'(8'hCC);
  localparam logic [DATA_WD-1:0] CMD_ALU_NO = DATA_WD'(8'hDD);
  localparam logic [ADDR_WD-1:0] ADDR_OPA   = {ADDR_WD{1'b0}};
  localparam logic [ADDR_WD-1:0] ADDR_OPB   = {{(ADDR_WD-1){1'b0}}, 1'b1};

  state_t             state;
  logic               rf_wr_en;
  logic               rf_rd_en;
  logic [ADDR_WD-1:0] rf_addr;
  logic [DATA_WD-1:0] rf_wr_data;
  logic               alu_en;
  logic [3:0]         alu_fun;
  logic               clk_gate_en;
  logic               cmd_busy;
  logic               cmd_err;

  logic byte_ok;
  logic in_frame;
  logic tmo_hit;

  // A frame error always wins over a byte presented in the same cycle.
  assign byte_ok  = bus.rx_d_vld & ~bus.rx_frm_err;
  assign in_frame = (state == ST_WR_ADDR) || (state == ST_WR_DATA) || (state == ST_RD_ADDR) ||
                    (state == ST_OPA)     || (state == ST_OPB)     || (state == ST_FUN);

`ifdef RX_TIMEOUT_EN
  logic [TIMEOUT_WD-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TIMEOUT_WD'(TIMEOUT_VAL - 1));

  // Inter-byte idle counter; only runs while a partial frame is pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= {TIMEOUT_WD{1'b0}};
    end else if (byte_ok || !in_frame || tmo_hit) begin
      tmo_cnt <= {TIMEOUT_WD{1'b0}};
    end else begin
      tmo_cnt <= tmo_cnt + {{(TIMEOUT_WD-1){1'b0}}, 1'b1};
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame-parsing state machine with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      rf_wr_en    <= 1'b0;
      rf_rd_en    <= 1'b0;
      rf_addr     <= {ADDR_WD{1'b0}};
      rf_wr_data  <= {DATA_WD{1'b0}};
      alu_en      <= 1'b0;
      alu_fun     <= 4'd0;
      clk_gate_en <= 1'b0;
      cmd_busy    <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      rf_wr_en <= 1'b0;
      rf_rd_en <= 1'b0;
      alu_en   <= 1'b0;
      cmd_err  <= 1'b0;
      if (in_frame && (bus.rx_frm_err || (!bus.rx_d_vld && tmo_hit))) begin
        state       <= ST_IDLE;
        cmd_busy    <= 1'b0;
        clk_gate_en <= 1'b0;
        cmd_err     <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_ok) begin
              case (bus.rx_p_data)
                CMD_WR: begin
                  state    <= ST_WR_ADDR;
                  cmd_busy <= 1'b1;
                end
                CMD_RD: begin
                  state    <= ST_RD_ADDR;
                  cmd_busy <= 1'b1;
                end
                CMD_ALU_OP: begin
                  state       <= ST_OPA;
                  cmd_busy    <= 1'b1;
                  clk_gate_en <= 1'b1;
                end
                CMD_ALU_NO: begin
                  state       <= ST_FUN;
                  cmd_busy    <= 1'b1;
                  clk_gate_en <= 1'b1;
                end
                default: begin
                  cmd_err <= 1'b1;
                end
              endcase
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_WR_ADDR: begin
            if (byte_ok) begin
              rf_addr <= bus.rx_p_data[ADDR_WD-1:0];
              state   <= ST_WR_DATA;
            end else begin
              state <= ST_WR_ADDR;
            end
          end
          ST_WR_DATA: begin
            if (byte_ok) begin
              rf_wr_data <= bus.rx_p_data;
              rf_wr_en   <= 1'b1;
              state      <= ST_IDLE;
              cmd_busy   <= 1'b0;
            end else begin
              state <= ST_WR_DATA;
            end
          end
          ST_RD_ADDR: begin
            if (byte_ok) begin
              rf_addr  <= bus.rx_p_data[ADDR_WD-1:0];
              rf_rd_en <= 1'b1;
              state    <= ST_IDLE;
              cmd_busy <= 1'b0;
            end else begin
              state <= ST_RD_ADDR;
            end
          end
          ST_OPA: begin
            if (byte_ok) begin
              rf_addr    <= ADDR_OPA;
              rf_wr_data <= bus.rx_p_data;
              rf_wr_en   <= 1'b1;
              state      <= ST_OPB;
            end else begin
              state <= ST_OPA;
            end
          end
          ST_OPB: begin
            if (byte_ok) begin
              rf_addr    <= ADDR_OPB;
              rf_wr_data <= bus.rx_p_data;
              rf_wr_en   <= 1'b1;
              state      <= ST_FUN;
            end else begin
              state <= ST_OPB;
            end
          end
          ST_FUN: begin
            if (byte_ok) begin
              alu_fun <= bus.rx_p_data[3:0];
              alu_en  <= 1'b1;
              state   <= ST_ALU_WAIT;
            end else begin
              state <= ST_FUN;
            end
          end
          ST_ALU_WAIT: begin
            // Bytes here are never part of a frame; they are dropped and flagged even as the ALU completes.
            if (byte_ok) begin
              cmd_err <= 1'b1;
            end else begin
              cmd_err <= 1'b0;
            end
            if (bus.alu_out_vld) begin
              state       <= ST_IDLE;
              cmd_busy    <= 1'b0;
              clk_gate_en <= 1'b0;
            end else begin
              state <= ST_ALU_WAIT;
            end
          end
          default: begin
            state       <= ST_IDLE;
            rf_addr     <= {ADDR_WD{1'b0}};
            rf_wr_data  <= {DATA_WD{1'b0}};
            alu_fun     <= 4'd0;
            clk_gate_en <= 1'b0;
            cmd_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rf_wr_en    = rf_wr_en;
  assign bus.rf_rd_en    = rf_rd_en;
  assign bus.rf_addr     = rf_addr;
  assign bus.rf_wr_data  = rf_wr_data;
  assign bus.alu_en      = alu_en;
  assign bus.alu_fun     = alu_fun;
  assign bus.clk_gate_en = clk_gate_en;
  assign bus.cmd_busy    = cmd_busy;
  assign bus.cmd_err     = cmd_err;

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Scoreboard bench for uart_rx_cmd_ctrl: a frame-level reference model queues expected strobes and levels,
// and an independent monitor compares them against whatever the DUT emits.
module tb_uart_rx_cmd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
`ifdef RX_TIMEOUT_EN
  localparam int TVAL = 16;
`endif

  typedef struct packed {
    logic [1:0] kind;   // 0 write, 1 read, 2 alu start, 3 error
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_cmd_ctrl_if #(.DATA_WD(DW), .ADDR_WD(AW)) bus ();

  uart_rx_cmd_ctrl #(
    .DATA_WD(DW), .ADDR_WD(AW)
`ifdef RX_TIMEOUT_EN
    , .TIMEOUT_WD(16), .TIMEOUT_VAL(TVAL)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  ev_t ev_q[$];
  logic [1:0] lvl_q[$];

  // Reference model state: which command is open, how many payload bytes seen, waiting for ALU.
  logic [7:0] m_cmd = 8'h00;
  int         m_pos = 0;
  logic       m_wait = 1'b0;
  logic [3:0] m_addr = 4'h0;
  int         m_gap = 0;

  function automatic ev_t mk(logic [1:0] k, logic [3:0] a, logic [7:0] d);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d;
    return e;
  endfunction

  function automatic void model_clear();
    m_cmd = 8'h00; m_pos = 0; m_wait = 1'b0; m_gap = 0;
  endfunction

  function automatic void model_step(logic v, logic [7:0] b, logic fe, logic aov);
    logic acc;
    acc = v && !fe;
    if (m_cmd == 8'h00) begin
      if (acc) begin
        if (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) begin
          m_cmd = b; m_pos = 0; m_gap = 0;
        end else begin
          ev_q.push_back(mk(2'd3, 4'h0, 8'h00));
        end
      end
    end else if (m_wait) begin
      if (acc) ev_q.push_back(mk(2'd3, 4'h0, 8'h00));
      if (aov) model_clear();
    end else if (fe) begin
      ev_q.push_back(mk(2'd3, 4'h0, 8'h00));
      model_clear();
    end else if (acc) begin
      m_gap = 0;
      if (m_cmd == 8'hAA) begin
        if (m_pos == 0) m_addr = b[3:0];
        else begin
          ev_q.push_back(mk(2'd0, m_addr, b));
          model_clear();
        end
      end else if (m_cmd == 8'hBB) begin
        ev_q.push_back(mk(2'd1, b[3:0], 8'h00));
        model_clear();
      end else if (m_cmd == 8'hCC && m_pos < 2) begin
        ev_q.push_back(mk(2'd0, (m_pos == 0) ? 4'h0 : 4'h1, b));
      end else begin
        ev_q.push_back(mk(2'd2, 4'h0, {4'h0, b[3:0]}));
        m_wait = 1'b1;
      end
      m_pos++;
    end else begin
`ifdef RX_TIMEOUT_EN
      m_gap++;
      if (m_gap == TVAL) begin
        ev_q.push_back(mk(2'd3, 4'h0, 8'h00));
        model_clear();
      end
`endif
    end
  endfunction

  // Drive one cycle of inputs and queue the expected busy/clock-gate levels for the following cycle.
  task automatic cyc(input logic v, input logic [7:0] b, input logic fe, input logic aov);
    @(posedge clk);
    #2;
    bus.rx_d_vld = v; bus.rx_p_data = b; bus.rx_frm_err = fe; bus.alu_out_vld = aov;
    model_step(v, b, fe, aov);
    lvl_q.push_back({(m_cmd != 8'h00), (m_cmd == 8'hCC || m_cmd == 8'hDD)});
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data, bus.alu_en, bus.alu_fun,
         bus.clk_gate_en, bus.cmd_busy, bus.cmd_err} !== '0) begin
      failures++;
      $display("FAIL %s got wr=%b rd=%b addr=%h data=%h alu_en=%b fun=%h cg=%b busy=%b err=%b required all zero",
               name, bus.rf_wr_en, bus.rf_rd_en, bus.rf_addr, bus.rf_wr_data, bus.alu_en, bus.alu_fun,
               bus.clk_gate_en, bus.cmd_busy, bus.cmd_err);
    end
  endtask

  // Monitor: one cycle after each drive, compare levels and pop the scoreboard on any strobe.
  logic [1:0] mon_lvl;
  ev_t        mon_got;
  ev_t        mon_exp;
  int         mon_n;
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (lvl_q.size() > 0) begin
        mon_lvl = lvl_q.pop_front();
        checks++;
        if ({bus.cmd_busy, bus.clk_gate_en} !== mon_lvl) begin
          failures++;
          $display("FAIL levels t=%0t got busy/cg=%b%b required %b", $time, bus.cmd_busy, bus.clk_gate_en, mon_lvl);
        end
      end
      mon_n = int'(bus.rf_wr_en) + int'(bus.rf_rd_en) + int'(bus.alu_en) + int'(bus.cmd_err);
      if (mon_n > 1) begin
        checks++; failures++;
        $display("FAIL strobes t=%0t got %0d simultaneous strobes required at most 1", $time, mon_n);
      end else if (mon_n == 1) begin
        if (bus.rf_wr_en)      mon_got = mk(2'd0, bus.rf_addr, bus.rf_wr_data);
        else if (bus.rf_rd_en) mon_got = mk(2'd1, bus.rf_addr, 8'h00);
        else if (bus.alu_en)   mon_got = mk(2'd2, 4'h0, {4'h0, bus.alu_fun});
        else                   mon_got = mk(2'd3, 4'h0, 8'h00);
        checks++;
        if (ev_q.size() == 0) begin
          failures++;
          $display("FAIL event t=%0t got kind=%0d addr=%h data=%h required no event", $time,
                   mon_got.kind, mon_got.addr, mon_got.data);
        end else begin
          mon_exp = ev_q.pop_front();
          if (mon_got !== mon_exp) begin
            failures++;
            $display("FAIL event t=%0t got kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h", $time,
                     mon_got.kind, mon_got.addr, mon_got.data, mon_exp.kind, mon_exp.addr, mon_exp.data);
          end
        end
      end
      if (mon_n == 0 && ev_q.size() > 0 && lvl_q.size() == 0) begin
        checks++; failures++;
        mon_exp = ev_q.pop_front();
        $display("FAIL event t=%0t got no strobe required kind=%0d addr=%h data=%h", $time,
                 mon_exp.kind, mon_exp.addr, mon_exp.data);
      end
    end
  end

  initial begin
    logic       v, fe, aov;
    logic [7:0] b;
    bus.rx_d_vld = 1'b0; bus.rx_p_data = 8'h00; bus.rx_frm_err = 1'b0; bus.alu_out_vld = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    send(8'hAA); send(8'h05); send(8'h3C); idle(2);
    send(8'hBB); send(8'hFA); idle(2);
    send(8'hCC); send(8'h12); send(8'h34); send(8'h02); idle(3);
    cyc(1'b0, 8'h00, 1'b0, 1'b1); idle(2);
    send(8'hDD); send(8'h07); idle(1); send(8'h55); idle(2);
    cyc(1'b1, 8'h66, 1'b0, 1'b1); idle(2);
    send(8'hAA); send(8'h03); cyc(1'b0, 8'h00, 1'b1, 1'b0); idle(2);
    send(8'h5A); idle(1);
    send(8'hCC); send(8'h11); cyc(1'b1, 8'h22, 1'b1, 1'b0); idle(2);
    cyc(1'b0, 8'h00, 1'b0, 1'b1); cyc(1'b0, 8'h00, 1'b1, 1'b0); idle(1);
`ifdef RX_TIMEOUT_EN
    send(8'hAA); idle(TVAL + 2);
    send(8'hAA); send(8'h01); send(8'h02); idle(2);
`endif

    // Reset in the middle of a frame drops it and zeroes every output.
    send(8'hAA); send(8'h09); idle(1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("reset_mid_frame");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    send(8'hBB); send(8'h04); idle(2);

    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 99) < 35);
      case ($urandom_range(0, 5))
        0: b = 8'hAA;
        1: b = 8'hBB;
        2: b = 8'hCC;
        3: b = 8'hDD;
        default: b = 8'($urandom_range(0, 255));
      endcase
      fe  = ($urandom_range(0, 19) == 0) && !(v && m_wait);
      aov = m_wait ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 29) == 0);
      cyc(v, b, fe, aov);
    end
    idle(4);
    @(posedge clk);
    #3;
    checks++;
    if (ev_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expected events required 0", ev_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
